// File: rtl/ls_capture_ctrl.sv
// Logic-slice capture sequencer: fills a pre-trigger window, waits for a
// masked edge trigger, completes the post-trigger window, then serves
// display scan reads from the single-port sample RAM it owns.
module ls_capture_ctrl #(
  parameter int DEPTH = 960,
  parameter int AW    = 10,
  parameter int NCH   = 4,
  parameter int PRE   = 120
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           arm,
  input  logic           sample_en,
  input  logic [NCH-1:0] din,
  input  logic [NCH-1:0] trig_mask,
  input  logic           trig_rise,
  input  logic           scan_req,
  input  logic [AW-1:0]  scan_n,
  output logic           scan_gnt,
  output logic           scan_valid,
  output logic [NCH-1:0] scan_data,
  output logic           ram_en,
  output logic           ram_we,
  output logic [AW-1:0]  ram_addr,
  output logic [NCH-1:0] ram_wdata,
  input  logic [NCH-1:0] ram_rdata,
  output logic           busy,
  output logic           done,
  output logic [AW-1:0]  trig_addr
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_e;

  localparam logic [AW-1:0] DEPTH_M1 = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_M1   = AW'(PRE - 1);
  localparam logic [AW-1:0] POST_M1  = AW'(DEPTH - PRE - 1);
  localparam logic [AW-1:0] PRE_A    = AW'(PRE);
  localparam logic [AW-1:0] WRAP_OFS = AW'(DEPTH - PRE);
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [NCH-1:0]   prev_q, prev_d;
  logic [AW-1:0]    trig_addr_q, trig_addr_d;
  logic             busy_q, done_q;
  logic             scan_valid_q, scan_ram_q;

  logic             capturing, wr_en, edge_hit, trig_now, rd_ram;
  logic [AW-1:0]    wp_inc, start, phys;
  logic [AW:0]      phys_full;

  // Write-side decode: a strobe in a capture state owns the RAM this cycle.
  always_comb begin
    capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
    wr_en     = capturing && sample_en && !arm;
    edge_hit  = |(trig_mask & (trig_rise ? (din & ~prev_q) : (~din & prev_q)));
    trig_now  = (state_q == S_WAIT) && ((trig_mask == '0) || edge_hit);
    wp_inc    = (wp_q == DEPTH_M1) ? '0 : wp_q + AW'(1);
  end

  // Scan-side decode: rotate the logical index by the window start address.
  always_comb begin
    start     = (trig_addr_q >= PRE_A) ? (trig_addr_q - PRE_A) : (trig_addr_q + WRAP_OFS);
    phys_full = {1'b0, start} + {1'b0, scan_n};
    if (phys_full >= DEPTH_W) phys_full = phys_full - DEPTH_W;
    phys      = phys_full[AW-1:0];
    // Capture writes always win; reads only outside a capture. Only DONE has
    // a meaningful start address, so IDLE reads and out-of-range indices
    // are acknowledged without touching the RAM and return zero.
    scan_gnt  = scan_req && !wr_en && ((state_q == S_IDLE) || (state_q == S_DONE));
    rd_ram    = scan_gnt && (state_q == S_DONE) && ({1'b0, scan_n} < DEPTH_W);
  end

  // RAM port mux.
  always_comb begin
    ram_en    = wr_en || rd_ram;
    ram_we    = wr_en;
    ram_addr  = wr_en ? wp_q : (rd_ram ? phys : '0);
    ram_wdata = wr_en ? din : '0;
  end

  // Capture sequencer next-state: arm restarts from any state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    wp_d        = wp_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    trig_addr_d = trig_addr_q;
    if (arm) begin
      state_d = S_PRE;
      wp_d    = '0;
      cnt_d   = '0;
    end else if (wr_en) begin
      wp_d   = wp_inc;
      prev_d = din;
      unique case (state_q)
        S_PRE: begin
          if (cnt_q == PRE_M1) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        S_WAIT: begin
          if (trig_now) begin
            trig_addr_d = wp_q;
            cnt_d       = AW'(1);
            state_d     = S_POST;
          end
        end
        S_POST: begin
          if (cnt_q == POST_M1) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State and registered status/scan outputs. The sample RAM is external and
  // deliberately not cleared; IDLE reads never reach it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wp_q         <= '0;
      cnt_q        <= '0;
      prev_q       <= '0;
      trig_addr_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      scan_valid_q <= 1'b0;
      scan_ram_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      wp_q         <= wp_d;
      cnt_q        <= cnt_d;
      prev_q       <= prev_d;
      trig_addr_q  <= trig_addr_d;
      busy_q       <= (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
      done_q       <= (state_d == S_DONE);
      scan_valid_q <= scan_gnt;
      scan_ram_q   <= rd_ram;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign trig_addr  = trig_addr_q;
  assign scan_valid = scan_valid_q;
  assign scan_data  = scan_ram_q ? ram_rdata : '0;

endmodule

// File: tb/tb_ls_capture_ctrl.sv
// Self-checking bench for ls_capture_ctrl with a behavioural RAM and a
// sample-sequence reference model of the pre/post trigger window.
module tb_ls_capture_ctrl;

  localparam int DEPTH = 960;
  localparam int AW    = 10;
  localparam int NCH   = 4;
  localparam int PRE   = 120;
  localparam int MAXS  = 4096;

  logic           clk, rst_n, arm, sample_en, trig_rise, scan_req;
  logic [NCH-1:0] din, trig_mask;
  logic [AW-1:0]  scan_n;
  logic           scan_gnt, scan_valid, ram_en, ram_we, busy, done;
  logic [NCH-1:0] scan_data, ram_wdata, ram_rdata;
  logic [AW-1:0]  ram_addr, trig_addr;

  int checks = 0;
  int errors = 0;

  logic [NCH-1:0] sam [MAXS];
  logic [NCH-1:0] mem [1 << AW];
  int             exp_trig_n;

  ls_capture_ctrl #(.DEPTH(DEPTH), .AW(AW), .NCH(NCH), .PRE(PRE)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .sample_en(sample_en), .din(din),
    .trig_mask(trig_mask), .trig_rise(trig_rise), .scan_req(scan_req),
    .scan_n(scan_n), .scan_gnt(scan_gnt), .scan_valid(scan_valid),
    .scan_data(scan_data), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .done(done), .trig_addr(trig_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with 1-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Sample sequence: masked channels sit at the inactive level until edge_n.
  task automatic gen_samples(input logic [NCH-1:0] mask, input logic rise, input int edge_n);
    logic [NCH-1:0] v;
    sam[0] = '0;
    for (int n = 1; n < MAXS; n++) begin
      v = NCH'($urandom);
      for (int c = 0; c < NCH; c++) begin
        if (mask[c]) begin
          if (n < edge_n)       v[c] = ~rise;
          else if (n == edge_n) v[c] = rise;
        end
      end
      sam[n] = v;
    end
  endtask

  // Reference: first strobe after the pre-trigger window whose masked channel
  // moved from the non-trigger level to the trigger level.
  function automatic int ref_trigger(input logic [NCH-1:0] mask, input logic rise);
    for (int n = PRE + 1; n < MAXS; n++) begin
      if (mask == '0) return n;
      for (int c = 0; c < NCH; c++)
        if (mask[c] && sam[n-1][c] !== rise && sam[n][c] === rise) return n;
    end
    return -1;
  endfunction

  task automatic arm_pulse();
    @(negedge clk); arm = 1'b1; sample_en = 1'b0;
    @(negedge clk); arm = 1'b0; #1;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL arm_state busy=%b done=%b required busy=1 done=0", busy, done);
    if (busy !== 1'b1 || done !== 1'b0) errors++;
  endtask

  // Drive nstrobes samples, checking every write and optionally a held scan request.
  task automatic drive_capture(input int nstrobes, input bit hold_req, input bit gaps);
    for (int n = 1; n <= nstrobes; n++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk); sample_en = 1'b0; #1;
          if (hold_req) begin
            checks++;
            if (scan_gnt !== 1'b0) begin
              errors++;
              $display("FAIL gnt_while_busy strobe=%0d gnt=%b required 0", n, scan_gnt);
            end
          end
        end
      end
      @(negedge clk); sample_en = 1'b1; din = sam[n]; #1;
      checks++;
      if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== AW'((n - 1) % DEPTH) ||
          ram_wdata !== sam[n] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL write strobe=%0d en=%b we=%b addr=%0d wdata=%h busy=%b done=%b required 1 1 %0d %h 1 0",
                 n, ram_en, ram_we, ram_addr, ram_wdata, busy, done, (n - 1) % DEPTH, sam[n]);
      end
      if (hold_req) begin
        checks++;
        if (scan_gnt !== 1'b0) begin
          errors++;
          $display("FAIL gnt_while_busy strobe=%0d gnt=%b required 0", n, scan_gnt);
        end
      end
    end
    @(negedge clk); sample_en = 1'b0; #1;
  endtask

  task automatic check_done(input string name);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || trig_addr !== AW'((exp_trig_n - 1) % DEPTH)) begin
      errors++;
      $display("FAIL %s done=%b busy=%b trig_addr=%0d required 1 0 %0d",
               name, done, busy, trig_addr, (exp_trig_n - 1) % DEPTH);
    end
  endtask

  task automatic full_capture(input logic [NCH-1:0] mask, input logic rise, input int edge_n,
                              input bit do_arm, input bit hold_req, input bit gaps, input string name);
    gen_samples(mask, rise, edge_n);
    exp_trig_n = ref_trigger(mask, rise);
    trig_mask  = mask;
    trig_rise  = rise;
    if (do_arm) arm_pulse();
    drive_capture(exp_trig_n + DEPTH - PRE - 1, hold_req, gaps);
    check_done(name);
  endtask

  // One scan read; zero_mode expects a zero result with no RAM access.
  task automatic scan_one(input int i, input bit zero_mode);
    bit             exp_en;
    logic [NCH-1:0] exp_d;
    int             exp_a;
    exp_en = !zero_mode && (i < DEPTH);
    exp_d  = exp_en ? sam[exp_trig_n - PRE + i] : '0;
    exp_a  = exp_en ? (exp_trig_n - PRE + i - 1) % DEPTH : 0;
    @(negedge clk); scan_req = 1'b1; scan_n = AW'(i); #1;
    checks++;
    if (scan_gnt !== 1'b1 || ram_en !== exp_en || ram_we !== 1'b0 ||
        (exp_en && ram_addr !== AW'(exp_a))) begin
      errors++;
      $display("FAIL scan_grant n=%0d gnt=%b en=%b we=%b addr=%0d required 1 %b 0 %0d",
               i, scan_gnt, ram_en, ram_we, ram_addr, exp_en, exp_a);
    end
    @(negedge clk); scan_req = 1'b0; #1;
    checks++;
    if (scan_valid !== 1'b1 || scan_data !== exp_d) begin
      errors++;
      $display("FAIL scan_data n=%0d valid=%b data=%h required 1 %h", i, scan_valid, scan_data, exp_d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; arm = 1'b0; sample_en = 1'b0; din = '0; trig_mask = '0;
    trig_rise = 1'b1; scan_req = 1'b0; scan_n = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (busy !== 0 || done !== 0 || scan_valid !== 0 || ram_en !== 0 || ram_we !== 0 ||
        ram_addr !== 0 || trig_addr !== 0 || scan_gnt !== 0 || scan_data !== 0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b valid=%b en=%b trig_addr=%0d required all 0",
               busy, done, scan_valid, ram_en, trig_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    scan_one(7, 1'b1);
  endtask

  task automatic test_reset_mid_post();
    gen_samples('0, 1'b1, 0);
    exp_trig_n = ref_trigger('0, 1'b1);
    trig_mask = '0;
    arm_pulse();
    drive_capture(300, 1'b0, 1'b0);
    @(negedge clk); rst_n = 1'b0; #1;
    checks++;
    if (busy !== 0 || done !== 0 || scan_valid !== 0 || ram_en !== 0 || trig_addr !== 0) begin
      errors++;
      $display("FAIL reset_mid_post busy=%b done=%b valid=%b en=%b trig_addr=%0d required 0",
               busy, done, scan_valid, ram_en, trig_addr);
    end
    @(negedge clk); rst_n = 1'b1;
    scan_one(0, 1'b1);
  endtask

  task automatic test_immediate();
    full_capture('0, 1'b1, 0, 1'b1, 1'b0, 1'b0, "immediate_done");
    scan_one(0, 1'b0);
    scan_one(DEPTH - 1, 1'b0);
    scan_one(1000, 1'b0);
  endtask

  task automatic test_rise_edge();
    full_capture(4'b0010, 1'b1, 500, 1'b1, 1'b0, 1'b0, "rise_trig");
    scan_one(PRE, 1'b0);
    scan_one(0, 1'b0);
    scan_one(DEPTH - 1, 1'b0);
  endtask

  task automatic test_wrap();
    full_capture(4'b1000, 1'b1, 1000, 1'b1, 1'b0, 1'b1, "wrap_trig");
    scan_one(200, 1'b0);
    scan_one(80, 1'b0);
    scan_one(81, 1'b0);
  endtask

  task automatic test_back_to_back();
    int             idx [10];
    logic [NCH-1:0] exp_d [10];
    @(negedge clk); scan_req = 1'b1; scan_n = '0;
    full_capture(4'b0001, 1'b1, 400, 1'b1, 1'b1, 1'b1, "held_req_done");
    checks++;
    if (scan_gnt !== 1'b1) begin
      errors++;
      $display("FAIL gnt_at_done gnt=%b required 1", scan_gnt);
    end
    for (int k = 0; k < 10; k++) begin
      idx[k]   = $urandom_range(0, DEPTH - 1);
      exp_d[k] = sam[exp_trig_n - PRE + idx[k]];
    end
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k < 10) scan_n = AW'(idx[k]);
      else        scan_req = 1'b0;
      #1;
      if (k < 10) begin
        checks++;
        if (scan_gnt !== 1'b1 || ram_en !== 1'b1 || ram_we !== 1'b0) begin
          errors++;
          $display("FAIL b2b_grant k=%0d gnt=%b en=%b we=%b required 1 1 0", k, scan_gnt, ram_en, ram_we);
        end
      end
      if (k > 0) begin
        checks++;
        if (scan_valid !== 1'b1 || scan_data !== exp_d[k-1]) begin
          errors++;
          $display("FAIL b2b_data k=%0d valid=%b data=%h required 1 %h", k - 1, scan_valid, scan_data, exp_d[k-1]);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if (scan_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_valid_drop valid=%b required 0", scan_valid);
    end
  endtask

  task automatic test_rearm_fall();
    gen_samples(4'b0100, 1'b0, PRE + 60);
    trig_mask = 4'b0100; trig_rise = 1'b0;
    arm_pulse();
    drive_capture(PRE + 30, 1'b0, 1'b0);
    arm_pulse();
    full_capture(4'b0100, 1'b0, 400, 1'b0, 1'b0, 1'b0, "fall_trig");
    scan_one(PRE, 1'b0);
    scan_one(PRE - 1, 1'b0);
  endtask

  task automatic test_random();
    logic [NCH-1:0] m;
    for (int it = 0; it < 3; it++) begin
      m = NCH'($urandom_range(1, (1 << NCH) - 1));
      full_capture(m, 1'($urandom), $urandom_range(PRE + 1, 1500), 1'b1, 1'b0, 1'b1, "random_trig");
      for (int r = 0; r < 4; r++) scan_one($urandom_range(0, DEPTH - 1), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_post();
    test_immediate();
    test_rise_edge();
    test_wrap();
    test_back_to_back();
    test_rearm_fall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
